e203_exu_alu_dpath_arb: RTL and testbench

- Arbiter and sequencer for the single shared ALU datapath in the EXU.
- Requesters, fixed by index: 0 = regular ALU, 1 = BJP, 2 = AGU, 3 = MULDIV.
- Round-robin grant among valid requesters.
- Lock mechanism lets a multi-cycle requester (MULDIV, AGU AMO) own the datapath across cycles.
- A lock-timeout watchdog force-releases a stuck owner.

---
 rtl/e203_alu_arb_pkg.sv | 30 +++
 rtl/e203_exu_alu_dpath_arb_if.sv | 32 +++
 rtl/e203_rr_pick.sv | 29 ++
 rtl/e203_exu_alu_dpath_arb.sv | 126 ++++++++++++
 tb/tb_e203_exu_alu_dpath_arb.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/e203_alu_arb_pkg.sv
// Shared definitions for the EXU ALU datapath arbiter: op encoding,
// requester indices and arbiter state.
package e203_alu_arb_pkg;

    localparam int ALU_OPW = 4;

    localparam logic [ALU_OPW-1:0] ALU_OP_NOP  = 4'h0;
    localparam logic [ALU_OPW-1:0] ALU_OP_ADD  = 4'h1;
    localparam logic [ALU_OPW-1:0] ALU_OP_SUB  = 4'h2;
    localparam logic [ALU_OPW-1:0] ALU_OP_XOR  = 4'h3;
    localparam logic [ALU_OPW-1:0] ALU_OP_SLL  = 4'h4;
    localparam logic [ALU_OPW-1:0] ALU_OP_SRL  = 4'h5;
    localparam logic [ALU_OPW-1:0] ALU_OP_SRA  = 4'h6;
    localparam logic [ALU_OPW-1:0] ALU_OP_OR   = 4'h7;
    localparam logic [ALU_OPW-1:0] ALU_OP_AND  = 4'h8;
    localparam logic [ALU_OPW-1:0] ALU_OP_SLT  = 4'h9;
    localparam logic [ALU_OPW-1:0] ALU_OP_SLTU = 4'hA;
    localparam logic [ALU_OPW-1:0] ALU_OP_LUI  = 4'hB;

    localparam int REQ_RGLR = 0;
    localparam int REQ_BJP  = 1;
    localparam int REQ_AGU  = 2;
    localparam int REQ_MDV  = 3;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/e203_exu_alu_dpath_arb_if.sv
// Requester-side and datapath-side signals of the shared ALU datapath arbiter.
interface e203_exu_alu_dpath_arb_if #(
    parameter int N    = 4,
    parameter int OPW  = 4,
    parameter int XLEN = 32
);
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      req_lock;
    logic [N*OPW-1:0]  req_op;
    logic [N*XLEN-1:0] req_op1;
    logic [N*XLEN-1:0] req_op2;
    logic [XLEN-1:0]   req_res;
    logic              dp_valid;
    logic              dp_ready;
    logic [OPW-1:0]    dp_op;
    logic [XLEN-1:0]   dp_op1;
    logic [XLEN-1:0]   dp_op2;
    logic [XLEN-1:0]   dp_res;

    // Environment side: requesters plus the datapath itself
    modport master (
        output req_valid, req_lock, req_op, req_op1, req_op2, dp_ready, dp_res,
        input  req_ready, req_res, dp_valid, dp_op, dp_op1, dp_op2
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_lock, req_op, req_op1, req_op2, dp_ready, dp_res,
        output req_ready, req_res, dp_valid, dp_op, dp_op1, dp_op2
    );
endinterface

// File: rtl/e203_rr_pick.sv
// Combinational round-robin picker: first valid bit at or after ptr, wrapping
// modulo N, returned as a one-hot grant and its index.
module e203_rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         valid,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx
);
    localparam int IW = $clog2(N);

    always_comb begin
        logic found;
        int   j;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!found && valid[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
    end
endmodule

// File: rtl/e203_exu_alu_dpath_arb.sv
// Round-robin arbiter for the shared EXU ALU datapath, with a lock so that a
// multi-cycle requester can own the datapath and a watchdog to break stuck locks.
//
// state     | meaning
// ----------|---------------------------------------------------------------
// ST_IDLE   | round-robin grant among valid requesters starting at rr_ptr
// ST_LOCKED | only the owner may be granted; lock_cnt counts idle cycles
module e203_exu_alu_dpath_arb
    import e203_alu_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int OPW      = ALU_OPW,
    parameter int XLEN     = 32,
    parameter int LOCK_TMO = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    e203_exu_alu_dpath_arb_if.slave bus,
    output logic [$clog2(N)-1:0]   grant_id,
    output logic                   locked,
    output logic                   lock_tmo
);
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(LOCK_TMO);

    arb_state_e    state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tmo_q, tmo_d;

    logic [N-1:0]  pick_grant;
    logic [IW-1:0] pick_idx;
    logic [N-1:0]  grant;
    logic [IW-1:0] gid;
    logic          hs;

    function automatic logic [IW-1:0] ptr_after(input logic [IW-1:0] i);
        return (int'(i) == N - 1) ? '0 : i + 1'b1;
    endfunction

    e203_rr_pick #(.N(N)) u_pick (
        .valid (bus.req_valid),
        .ptr   (rr_ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    always_comb begin
        grant = '0;
        gid   = '0;
        if (state_q == ST_IDLE) begin
            grant = pick_grant;
            gid   = pick_idx;
        end else if (bus.req_valid[owner_q]) begin
            grant[owner_q] = 1'b1;
            gid            = owner_q;
        end
    end

    assign hs            = (|grant) & bus.dp_ready;
    assign bus.req_ready = grant & {N{bus.dp_ready}};
    assign bus.dp_valid  = |grant;
    assign bus.dp_op     = (|grant) ? bus.req_op[int'(gid)*OPW +: OPW]    : '0;
    assign bus.dp_op1    = (|grant) ? bus.req_op1[int'(gid)*XLEN +: XLEN] : '0;
    assign bus.dp_op2    = (|grant) ? bus.req_op2[int'(gid)*XLEN +: XLEN] : '0;
    assign bus.req_res   = bus.dp_res;
    assign grant_id      = gid;
    assign locked        = (state_q == ST_LOCKED);
    assign lock_tmo      = tmo_q;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        tmo_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hs) begin
                    if (bus.req_lock[gid]) begin
                        state_d = ST_LOCKED;
                        owner_d = gid;
                        cnt_d   = '0;
                    end else begin
                        rr_ptr_d = ptr_after(gid);
                    end
                end
            end
            ST_LOCKED: begin
                // An owner handshake wins over the watchdog in the same cycle
                if (hs) begin
                    cnt_d = '0;
                    if (!bus.req_lock[owner_q]) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = ptr_after(owner_q);
                    end
                end else if (cnt_q == CW'(LOCK_TMO - 1)) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = ptr_after(owner_q);
                    cnt_d    = '0;
                    tmo_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            cnt_q    <= '0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
        end
    end
endmodule

// File: tb/tb_e203_exu_alu_dpath_arb.sv
// Directed bench for the EXU ALU datapath arbiter: round-robin, lock, watchdog,
// back-pressure and reset during a lock.
module tb_e203_exu_alu_dpath_arb;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  grant_id;
    logic        locked;
    logic        lock_tmo;
    logic [31:0] res_val;
    int          n_assert = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    e203_exu_alu_dpath_arb_if #(.N(4), .OPW(4), .XLEN(32)) bus ();

    e203_exu_alu_dpath_arb #(.N(4), .OPW(4), .XLEN(32), .LOCK_TMO(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .grant_id (grant_id),
        .locked   (locked),
        .lock_tmo (lock_tmo)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the falling edge; checks follow 1 time unit later
    task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic r);
        @(negedge clk);
        bus.req_valid = v;
        bus.req_lock  = l;
        bus.dp_ready  = r;
        res_val       = res_val + 32'h0101_0011;
        bus.dp_res    = res_val;
        #1;
    endtask

    task automatic chk_bus(input string tag, input int gid, input logic [3:0] ready, input logic dv);
        chk({tag, ".gid"},   32'(grant_id),      32'(gid));
        chk({tag, ".ready"}, 32'(bus.req_ready), 32'(ready));
        chk({tag, ".dpv"},   32'(bus.dp_valid),  32'(dv));
        chk({tag, ".op"},    32'(bus.dp_op),     dv ? 32'(gid + 1) : 32'h0);
        chk({tag, ".op1"},   bus.dp_op1,         dv ? 32'h0000_00A0 + 32'(gid) : 32'h0);
        chk({tag, ".op2"},   bus.dp_op2,         dv ? 32'h0000_00B0 + 32'(gid) : 32'h0);
        chk({tag, ".res"},   bus.req_res,        res_val);
    endtask

    task automatic chk_st(input string tag, input logic lk, input logic tmo);
        chk({tag, ".locked"}, 32'(locked),   32'(lk));
        chk({tag, ".tmo"},    32'(lock_tmo), 32'(tmo));
    endtask

    initial begin
        rst           = 1'b1;
        res_val       = 32'h0;
        bus.req_valid = '0;
        bus.req_lock  = '0;
        bus.dp_ready  = 1'b0;
        bus.dp_res    = '0;
        for (int i = 0; i < 4; i++) begin
            bus.req_op[i*4 +: 4]    = 4'(i + 1);
            bus.req_op1[i*32 +: 32] = 32'h0000_00A0 + 32'(i);
            bus.req_op2[i*32 +: 32] = 32'h0000_00B0 + 32'(i);
        end

        // Reset values, no requests
        drive(4'b0000, 4'b0000, 1'b1);
        chk_bus("rst", 0, 4'b0000, 1'b0);
        chk_st("rst", 1'b0, 1'b0);
        rst = 1'b0;
        drive(4'b0000, 4'b0000, 1'b1);
        chk_bus("idle_none", 0, 4'b0000, 1'b0);

        // Round-robin with all four requesting
        for (int k = 0; k < 7; k++) begin
            drive(4'b1111, 4'b0000, 1'b1);
            chk_bus($sformatf("rr%0d", k), k % 4, 4'(1 << (k % 4)), 1'b1);
        end

        // MULDIV locks for four handshakes, others stay valid
        drive(4'b1111, 4'b1000, 1'b1);
        chk_bus("lk0", 3, 4'b1000, 1'b1);
        chk_st("lk0", 1'b0, 1'b0);
        for (int c = 1; c <= 2; c++) begin
            drive(4'b1111, 4'b1000, 1'b1);
            chk_bus($sformatf("lk%0d", c), 3, 4'b1000, 1'b1);
            chk_st($sformatf("lk%0d", c), 1'b1, 1'b0);
        end
        drive(4'b1111, 4'b0000, 1'b1);
        chk_bus("lk3", 3, 4'b1000, 1'b1);
        chk_st("lk3", 1'b1, 1'b0);
        drive(4'b1111, 4'b0000, 1'b1);
        chk_bus("lk4", 0, 4'b0001, 1'b1);
        chk_st("lk4", 1'b0, 1'b0);

        // Owner locks then vanishes: watchdog fires after 16 locked cycles
        drive(4'b1000, 4'b1000, 1'b1);
        chk_bus("to0", 3, 4'b1000, 1'b1);
        for (int c = 1; c <= 16; c++) begin
            drive(4'b0111, 4'b0000, 1'b1);
            chk_bus($sformatf("to%0d", c), 0, 4'b0000, 1'b0);
            chk_st($sformatf("to%0d", c), 1'b1, 1'b0);
        end
        drive(4'b0111, 4'b0000, 1'b1);
        chk_bus("to17", 0, 4'b0001, 1'b1);
        chk_st("to17", 1'b0, 1'b1);
        drive(4'b0111, 4'b0000, 1'b1);
        chk_bus("to18", 1, 4'b0010, 1'b1);
        chk_st("to18", 1'b0, 1'b0);

        // Owner stalled by dp_ready=0, then releases exactly on the last count
        drive(4'b1000, 4'b1000, 1'b1);
        chk_bus("th0", 3, 4'b1000, 1'b1);
        for (int c = 1; c <= 15; c++) begin
            drive(4'b1000, 4'b1000, 1'b0);
            chk_bus($sformatf("th%0d", c), 3, 4'b0000, 1'b1);
            chk_st($sformatf("th%0d", c), 1'b1, 1'b0);
        end
        drive(4'b1001, 4'b0000, 1'b1);
        chk_bus("th16", 3, 4'b1000, 1'b1);
        chk_st("th16", 1'b1, 1'b0);
        drive(4'b1111, 4'b0000, 1'b1);
        chk_bus("th17", 0, 4'b0001, 1'b1);
        chk_st("th17", 1'b0, 1'b0);

        // Back-pressure holds the grant and the pointer
        for (int c = 0; c < 3; c++) begin
            drive(4'b0110, 4'b0000, 1'b0);
            chk_bus($sformatf("bp%0d", c), 1, 4'b0000, 1'b1);
        end
        drive(4'b0110, 4'b0000, 1'b1);
        chk_bus("bp3", 1, 4'b0010, 1'b1);
        drive(4'b0110, 4'b0000, 1'b1);
        chk_bus("bp4", 2, 4'b0100, 1'b1);

        // Reset asserted mid-cycle while MULDIV holds the lock
        drive(4'b1111, 4'b1000, 1'b1);
        chk_bus("rl0", 3, 4'b1000, 1'b1);
        drive(4'b1111, 4'b1000, 1'b1);
        chk_st("rl1", 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk_st("rl_async", 1'b0, 1'b0);
        chk("rl_async.gid", 32'(grant_id), 32'd0);
        drive(4'b1111, 4'b0000, 1'b1);
        rst = 1'b0;
        #1;
        chk_bus("rl_rel", 0, 4'b0001, 1'b1);
        chk_st("rl_rel", 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
